// File: rtl/stage0_ctrl_p.sv
// Stage-0 (fetch) controller: PC, one/two-word fetch, valid/ready hand-off, interrupts, flush.
// Optional STAGE0_PERF_EN adds saturating transfer/stall counters.
module stage0_ctrl_p #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INSTR_W  = 8,
  parameter int                 DATA_W   = 8,
  parameter int                 CTRL_W   = 21,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  INT_VEC  = 8'hF0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  data,
  input  logic               i_pending,
  input  logic               i_done,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr,
  input  logic               stg1_state,
  output logic               stg0_state,
  output logic [INSTR_W-1:0] ir_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  ret_pc,
  output logic               i_ack,
  output logic [CTRL_W-1:0]  ctrl
`ifdef STAGE0_PERF_EN
  ,
  output logic [15:0]        perf_instr,
  output logic [15:0]        perf_stall
`endif
);

  // Handshake: stg0_state is valid, stg1_state is ready; an instruction moves to
  // stage 1 on a rising edge where both are high while in S_HAND.
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DATA  = 3'd1,
    S_HAND  = 3'd2,
    S_INT0  = 3'd3,
    S_INT1  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  ret_pc_q, ret_pc_d;
  logic               in_service_q, in_service_d;
  logic               valid_q, valid_d;
  logic               i_ack_q, i_ack_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               transfer;

  assign transfer = (state_q == S_HAND) && stg1_state;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    data_d   = data_q;
    ret_pc_d = ret_pc_q;

    // Entry set beats a coincident i_done; an aborted entry (flush) never sets.
    if ((state_q == S_INT0) && !flush) in_service_d = 1'b1;
    else if (i_done)                   in_service_d = 1'b0;
    else                               in_service_d = in_service_q;

    case (state_q)
      S_FETCH: begin
        ir_d = instr;
        pc_d = pc_q + ADDR_W'(1);
        if (instr[INSTR_W-1]) begin
          state_d = S_DATA;
        end else begin
          data_d  = '0;
          state_d = S_HAND;
        end
      end
      S_DATA: begin
        data_d  = data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_HAND;
      end
      S_HAND: begin
        if (transfer) begin
          if (i_pending && !in_service_q) state_d = S_INT0;
          else                            state_d = S_FETCH;
        end
      end
      S_INT0: begin
        ret_pc_d = pc_q;
        state_d  = S_INT1;
      end
      S_INT1: begin
        pc_d    = INT_VEC;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Redirect overrides every register update except the PC target itself.
    if (flush) begin
      state_d  = S_FETCH;
      pc_d     = flush_addr;
      ir_d     = ir_q;
      data_d   = data_q;
      ret_pc_d = ret_pc_q;
    end

    // Outputs are registered decodes of the state being entered.
    valid_d = (state_d == S_HAND);
    i_ack_d = (state_d == S_INT1);
    ctrl_d  = '0;
    case (state_d)
      S_FETCH: begin ctrl_d[0] = 1'b1; ctrl_d[1] = 1'b1; end
      S_DATA:  begin ctrl_d[0] = 1'b1; ctrl_d[2] = 1'b1; end
      S_INT0:  ctrl_d[4] = 1'b1;
      S_INT1:  ctrl_d[3] = 1'b1;
      default: ;
    endcase
    ctrl_d[5] = in_service_d;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      data_q       <= '0;
      ret_pc_q     <= '0;
      in_service_q <= 1'b0;
      valid_q      <= 1'b0;
      i_ack_q      <= 1'b0;
      ctrl_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      data_q       <= data_d;
      ret_pc_q     <= ret_pc_d;
      in_service_q <= in_service_d;
      valid_q      <= valid_d;
      i_ack_q      <= i_ack_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign stg0_state = valid_q;
  assign ir_out     = ir_q;
  assign data_out   = data_q;
  assign pc_out     = pc_q;
  assign ret_pc     = ret_pc_q;
  assign i_ack      = i_ack_q;
  assign ctrl       = ctrl_q;

`ifdef STAGE0_PERF_EN
  logic [15:0] perf_instr_q, perf_instr_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_stall_d = perf_stall_q;
    if (transfer && (perf_instr_q != 16'hFFFF))
      perf_instr_d = perf_instr_q + 16'd1;
    if ((state_q == S_HAND) && !stg1_state && (perf_stall_q != 16'hFFFF))
      perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_stage0_ctrl_p.sv
// Directed bench for stage0_ctrl_p: scoreboard of hand-off beats plus point checks.
module tb_stage0_ctrl_p;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  instr;
  logic [7:0]  data;
  logic        i_pending;
  logic        i_done;
  logic        flush;
  logic [7:0]  flush_addr;
  logic        stg1_state;
  logic        stg0_state;
  logic [7:0]  ir_out;
  logic [7:0]  data_out;
  logic [7:0]  pc_out;
  logic [7:0]  ret_pc;
  logic        i_ack;
  logic [20:0] ctrl;
`ifdef STAGE0_PERF_EN
  logic [15:0] perf_instr;
  logic [15:0] perf_stall;
`endif

  logic [7:0]  imem [256];
  logic [7:0]  dmem [256];
  logic [23:0] exp_q [$];
  int          n_vec  = 0;
  int          n_fail = 0;

  stage0_ctrl_p dut (
    .clk        (clk),
    .clr        (clr),
    .instr      (instr),
    .data       (data),
    .i_pending  (i_pending),
    .i_done     (i_done),
    .flush      (flush),
    .flush_addr (flush_addr),
    .stg1_state (stg1_state),
    .stg0_state (stg0_state),
    .ir_out     (ir_out),
    .data_out   (data_out),
    .pc_out     (pc_out),
    .ret_pc     (ret_pc),
    .i_ack      (i_ack),
    .ctrl       (ctrl)
`ifdef STAGE0_PERF_EN
    ,
    .perf_instr (perf_instr),
    .perf_stall (perf_stall)
`endif
  );

  // Clock / memory model
  always #5 clk = ~clk;
  assign instr = imem[pc_out];
  assign data  = dmem[pc_out];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each accepted beat {ir_out, data_out, pc_out} is popped and compared.
  always @(negedge clk) begin
    if (!clr && stg0_state && stg1_state) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", {8'h00, ir_out, data_out, pc_out}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("beat", {8'h00, ir_out, data_out, pc_out}, {8'h00, e});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'h00;
      dmem[i] = 8'h00;
    end
    imem[8'h00] = 8'h12;
    imem[8'hFF] = 8'h85;
    dmem[8'h00] = 8'h3C;
    imem[8'h06] = 8'h21;
    imem[8'hF0] = 8'h44;
    imem[8'hF1] = 8'h55;
    imem[8'h30] = 8'h05;
    imem[8'h50] = 8'h9A;
    dmem[8'h51] = 8'h77;
    imem[8'h40] = 8'h11;
    imem[8'h60] = 8'hC0;
    dmem[8'h61] = 8'hAB;

    clr = 1'b1; i_pending = 1'b0; i_done = 1'b0; flush = 1'b0;
    flush_addr = 8'h00; stg1_state = 1'b1;
    tick(); tick();
    chk("rst_pc", {24'h0, pc_out}, 32'h00);
    chk("rst_misc", {ir_out, data_out, ret_pc, 6'b0, stg0_state, i_ack}, 32'h0);
    chk("rst_ctrl", {11'h0, ctrl}, 32'h0);
    clr = 1'b0;

    // One-word fetch and immediate transfer
    exp_q.push_back({8'h12, 8'h00, 8'h01});
    tick();
    chk("w1_pc", {24'h0, pc_out}, 32'h01);
    chk("w1_valid", {31'h0, stg0_state}, 32'h1);
    tick();
    chk("w1_done_valid", {31'h0, stg0_state}, 32'h0);
    chk("w1_fetch_ctrl", {11'h0, ctrl}, 32'h03);

    // Two-word fetch straddling the PC wrap
    flush = 1'b1; flush_addr = 8'hFF;
    tick();
    flush = 1'b0;
    chk("flush_pc_ff", {24'h0, pc_out}, 32'hFF);
    exp_q.push_back({8'h85, 8'h3C, 8'h01});
    tick();
    chk("w2_data_ctrl", {11'h0, ctrl}, 32'h05);
    chk("w2_not_valid", {31'h0, stg0_state}, 32'h0);
    stg1_state = 1'b0;
    tick();
    chk("w2_pc_wrap", {24'h0, pc_out}, 32'h01);

    // Stall: five cycles with stage 1 not ready
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {stg0_state, 2'b0, ctrl[4:0], ir_out, data_out, pc_out}, {1'b1, 7'h0, 24'h853C01});
    end
`ifdef STAGE0_PERF_EN
    chk("perf_stall", {16'h0, perf_stall}, 32'd5);
    chk("perf_instr_stalled", {16'h0, perf_instr}, 32'd1);
`endif
    stg1_state = 1'b1;
    tick();

    // Interrupt taken at the boundary after the instruction at 0x06
    flush = 1'b1; flush_addr = 8'h06;
    tick();
    flush = 1'b0;
    exp_q.push_back({8'h21, 8'h00, 8'h07});
    i_pending = 1'b1;
    tick();
    tick();
    chk("int0_ctrl", {11'h0, ctrl}, 32'h10);
    tick();
    chk("int1_ret_pc", {24'h0, ret_pc}, 32'h07);
    chk("int1_ack", {31'h0, i_ack}, 32'h1);
    chk("int1_ctrl", {11'h0, ctrl}, 32'h28);
    tick();
    chk("vec_pc", {24'h0, pc_out}, 32'hF0);
    chk("ack_pulse_end", {31'h0, i_ack}, 32'h0);
    chk("vec_ctrl", {11'h0, ctrl}, 32'h23);

    // Still in service: the pending request must not nest
    exp_q.push_back({8'h44, 8'h00, 8'hF1});
    tick();
    tick();
    chk("no_nest_ctrl", {11'h0, ctrl}, 32'h23);
    exp_q.push_back({8'h55, 8'h00, 8'hF2});
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("idone_ctrl", {11'h0, ctrl}, 32'h00);
    tick();
    chk("retake_int0", {11'h0, ctrl}, 32'h10);
    tick();
    chk("retake_ret_pc", {24'h0, ret_pc}, 32'hF2);

    // Flush during S_INT1 beats the vector load
    flush = 1'b1; flush_addr = 8'h30; i_pending = 1'b0;
    tick();
    flush = 1'b0;
    chk("int1_flush_pc", {24'h0, pc_out}, 32'h30);
    exp_q.push_back({8'h05, 8'h00, 8'h31});
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    i_pending = 1'b1;
    tick();
    chk("int0_again", {11'h0, ctrl}, 32'h10);

    // Flush during S_INT0 aborts entry
    flush = 1'b1; flush_addr = 8'h50; i_pending = 1'b0;
    tick();
    flush = 1'b0;
    chk("int0_flush_ret_pc", {24'h0, ret_pc}, 32'hF2);
    chk("int0_flush_ctrl", {11'h0, ctrl}, 32'h03);
    chk("int0_flush_pc", {24'h0, pc_out}, 32'h50);
    chk("int0_flush_noack", {31'h0, i_ack}, 32'h0);

    // Flush during S_DATA
    tick();
    flush = 1'b1; flush_addr = 8'h40;
    tick();
    flush = 1'b0;
    chk("data_flush_valid", {31'h0, stg0_state}, 32'h0);
    chk("data_flush_pc", {24'h0, pc_out}, 32'h40);
    exp_q.push_back({8'h11, 8'h00, 8'h41});
    tick();

    // Flush coincident with a transfer: beat accepted, PC redirected
    flush = 1'b1; flush_addr = 8'h60;
    tick();
    flush = 1'b0;
    chk("hand_flush_pc", {24'h0, pc_out}, 32'h60);
`ifdef STAGE0_PERF_EN
    chk("perf_instr_total", {16'h0, perf_instr}, 32'd7);
`endif

    // Asynchronous reset in the middle of S_DATA
    tick();
    chk("pre_clr_data_ctrl", {11'h0, ctrl}, 32'h05);
    #2 clr = 1'b1;
    #1;
    chk("async_pc", {24'h0, pc_out}, 32'h00);
    chk("async_misc", {ir_out, data_out, ret_pc, 6'b0, stg0_state, i_ack}, 32'h0);
    chk("async_ctrl", {11'h0, ctrl}, 32'h0);
    tick();
    clr = 1'b0;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
